// File: rtl/alu_multicycle.sv
// Multi-cycle sliced ALU: DATA_W-bit ops computed SLICE_W bits per clock,
// LSB first, with a carry/borrow chain register and valid/ready handshakes.
module alu_multicycle #(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] op_A,
  input  logic [DATA_W-1:0] op_B,
  input  logic [3:0]        in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [3:0]        next_flags,
  output logic              op_err
);

  localparam int N_SLICE = DATA_W / SLICE_W;
  localparam int IDX_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
  localparam int BASE_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SLICE - 1);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SBC = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_CP  = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        fl_q, fl_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [3:0]        nf_q, nf_d;
  logic              err_q, err_d;

  logic [BASE_W-1:0]  base;
  logic               is_sub, zero_a, cin0, cin, cin_add;
  logic [SLICE_W-1:0] sa, sb, sbx, sres;
  logic [SLICE_W:0]   ssum;
  logic [4:0]         nsum;
  logic               co, hc, z;

  // Subtraction runs as A + ~B + ~borrow; carry_q always holds borrow for subs
  always_comb begin
    base   = BASE_W'(int'(idx_q) * SLICE_W);
    is_sub = (op_q == OP_SUB) || (op_q == OP_SBC) ||
             (op_q == OP_DEC) || (op_q == OP_CP);
    zero_a = (op_q == OP_INC) || (op_q == OP_DEC);
    unique case (1'b1)
      (op_q == OP_ADC) || (op_q == OP_SBC): cin0 = fl_q[0];
      zero_a:                               cin0 = 1'b1;
      default:                              cin0 = 1'b0;
    endcase
    cin     = (idx_q == '0) ? cin0 : carry_q;
    sa      = zero_a ? '0 : a_q[base +: SLICE_W];
    sb      = b_q[base +: SLICE_W];
    sbx     = is_sub ? ~sb : sb;
    cin_add = is_sub ? ~cin : cin;
    ssum    = {1'b0, sa} + {1'b0, sbx} + {{SLICE_W{1'b0}}, cin_add};
    nsum    = {1'b0, sa[3:0]} + {1'b0, sbx[3:0]} + {4'b0, cin_add};
    co      = is_sub ? ~ssum[SLICE_W] : ssum[SLICE_W];
    hc      = is_sub ? ~nsum[4] : nsum[4];
    unique case (op_q)
      OP_AND:  sres = sa & sb;
      OP_OR:   sres = sa | sb;
      OP_XOR:  sres = sa ^ sb;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC,
      OP_INC, OP_DEC, OP_CP:
               sres = ssum[SLICE_W-1:0];
      default: sres = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    fl_d    = fl_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    res_d   = res_q;
    nf_d    = nf_q;
    err_d   = err_q;
    z       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op_code;
          a_d     = op_A;
          b_d     = op_B;
          fl_d    = in_flags;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d[base +: SLICE_W] = sres;
        carry_d = co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
          z       = (acc_d == '0);
          res_d   = acc_d;
          err_d   = 1'b0;
          unique case (op_q)
            OP_NOP: begin
              res_d = b_q;
              nf_d  = fl_q;
            end
            OP_ADD, OP_ADC: nf_d = {z, 1'b0, hc, co};
            OP_SUB, OP_SBC: nf_d = {z, 1'b1, hc, co};
            OP_INC: nf_d = {z, 1'b0, hc, fl_q[0]};
            OP_DEC: nf_d = {z, 1'b1, hc, fl_q[0]};
            OP_CP: begin
              res_d = a_q;
              nf_d  = {z, 1'b1, hc, co};
            end
            OP_AND: nf_d = {z, 3'b010};
            OP_OR, OP_XOR: nf_d = {z, 3'b000};
            default: begin
              res_d = '0;
              nf_d  = fl_q;
              err_d = 1'b1;
            end
          endcase
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fl_q    <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      nf_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fl_q    <= fl_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      nf_q    <= nf_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign alu_result = res_q;
  assign next_flags = nf_q;
  assign op_err     = out_valid & err_q;

endmodule
